// File: rtl/toggle_rr_arbiter.sv
// Round-robin arbiter that shares one toggle cell among N requesters and confirms each flip of z1.
// Optional feature: define TOGGLE_CNT_EN to add the 16-bit successful-toggle counter port toggle_cnt.
module toggle_rr_arbiter #(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 8,
  localparam int IDX_W   = $clog2(N),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     req,
  input  logic             z1,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] owner,
  output logic             ack,
  output logic             err,
  output logic             togen,
  output logic             busy
`ifdef TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CHECK,
    S_ACK,
    S_ERR
  } state_t;

  localparam logic [IDX_W:0]   N_W       = (IDX_W + 1)'(N);
  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             togen_q, togen_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             z1_before_q, z1_before_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] tcnt_inc;
  logic [IDX_W-1:0] pick;

  // Scans last+1 .. last+N (mod N); walking the offsets downward leaves the
  // nearest set request as the final assignment.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    rr_pick = last;
    for (int i = N; i >= 1; i--) begin
      sum = {1'b0, last} + (IDX_W + 1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      idx = IDX_W'(sum);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick     = rr_pick(req, last_q);
  assign tcnt_inc = tcnt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    togen_d     = 1'b0;
    last_d      = last_q;
    z1_before_d = z1_before_q;
    tcnt_d      = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d = S_GRANT;
          grant_d = ONE_HOT0 << pick;
          owner_d = pick;
          togen_d = 1'b1;
          tcnt_d  = '0;
        end
      end

      S_GRANT: begin
        // The cell flips on the edge that leaves GRANT, so z1 here is still the old value.
        z1_before_d = z1;
        state_d     = S_CHECK;
      end

      S_CHECK: begin
        tcnt_d = tcnt_inc;
        if (z1 != z1_before_q) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else if (tcnt_inc == TIMEOUT_W) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end

      S_ACK, S_ERR: begin
        last_d  = owner_q;
        grant_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      grant_q     <= '0;
      owner_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      togen_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= IDX_W'(N - 1);
      z1_before_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      togen_q     <= togen_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      z1_before_q <= z1_before_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign togen = togen_q;
  assign busy  = busy_q;

`ifdef TOGGLE_CNT_EN
  logic [15:0] toggle_cnt_q;
  logic        toggle_inc;

  assign toggle_inc = (state_q == S_CHECK) && (state_d == S_ACK);

  always_ff @(posedge clk) begin
    if (clr)             toggle_cnt_q <= '0;
    else if (toggle_inc) toggle_cnt_q <= toggle_cnt_q + 16'd1;
  end

  assign toggle_cnt = toggle_cnt_q;
`endif

endmodule
